// File: rtl/spi_master_if.sv
// Bundles the spi_master user side (request/response) and the SPI pins.
// The master modport is the controller's view; slave is the environment's view.
interface spi_master_if #(
  parameter int DATA_W = 8
);
  logic              stutter_in;
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              miso;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              mosi;
  logic              ss;
  logic              st;

  modport master (
    input  stutter_in, start, tx_data, miso,
    output busy, done, rx_data, sclk, mosi, ss, st
  );

  modport slave (
    output stutter_in, start, tx_data, miso,
    input  busy, done, rx_data, sclk, mosi, ss, st
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master, one DATA_W word per transfer; all outputs registered, done (2*DATA_W+1)*CLK_DIV+1 cycles after accept.
// No queueing: start is only taken in IDLE without stutter; stutter_in freezes everything except st.
module spi_master #(
  parameter int DATA_W       = 8,
  parameter int CLK_DIV      = 2,
  parameter int RX_LSB_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_master_if.master  bus
);
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;

  state_t            state, state_d;
  logic [DIV_W-1:0]  div_cnt, div_d;
  logic [BIT_W-1:0]  bit_cnt, bit_d;
  logic [DATA_W-1:0] tx_sr, tx_sr_d;
  logic [DATA_W-1:0] rx_sr, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ss_q, ss_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              st_q;
  logic              div_last;

  assign div_last = (div_cnt == DIV_LAST);

  always_comb begin
    state_d   = state;
    div_d     = div_cnt;
    bit_d     = bit_cnt;
    tx_sr_d   = tx_sr;
    rx_sr_d   = rx_sr;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_d      = ss_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (state != IDLE) begin
      div_d = div_last ? '0 : div_cnt + DIV_W'(1);
    end
    case (state)
      IDLE: begin
        if (bus.start) begin
          tx_sr_d = bus.tx_data;
          rx_sr_d = '0;
          bit_d   = '0;
          div_d   = '0;
          ss_d    = 1'b0;
          mosi_d  = bus.tx_data[DATA_W-1];
          busy_d  = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (div_last) begin
          sclk_d = 1'b1;
          // miso is sampled in the same cycle the rising edge is launched
          if (RX_LSB_FIRST != 0) begin
            rx_sr_d = {bus.miso, rx_sr[DATA_W-1:1]};
          end else begin
            rx_sr_d = {rx_sr[DATA_W-2:0], bus.miso};
          end
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (div_last) begin
          sclk_d = 1'b0;
          bit_d  = bit_cnt + BIT_W'(1);
          if (bit_cnt != BIT_LAST) begin
            tx_sr_d = tx_sr << 1;
            mosi_d  = tx_sr[DATA_W-2];
            state_d = LOW;
          end else begin
            mosi_d  = 1'b0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (div_last) begin
          ss_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (div_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      st_q      <= 1'b0;
    end else begin
      st_q <= bus.stutter_in;
      if (!bus.stutter_in) begin
        state     <= state_d;
        div_cnt   <= div_d;
        bit_cnt   <= bit_d;
        tx_sr     <= tx_sr_d;
        rx_sr     <= rx_sr_d;
        rx_data_q <= rx_data_d;
        sclk_q    <= sclk_d;
        mosi_q    <= mosi_d;
        ss_q      <= ss_d;
        busy_q    <= busy_d;
        done_q    <= done_d;
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.ss      = ss_q;
  assign bus.st      = st_q;
endmodule
